cpu_regfile_mp: RTL and testbench
=================================

// Module: cpu_regfile_mp
// PURPOSE
//   Parametrised multi-port CPU register file: 1 write port, 2 independent read
//   ports, optional write-through bypass, optional registered reads, and a
//   per-register busy scoreboard for in-flight destination writes. Sits between
//   decode (read/issue) and writeback; replaces the single-read tri-state file.
// PARAMETERS
//   WIDTH     16  data width of each register, in bits
//   DEPTH     8   number of registers, >=2, power of two; AW = $clog2(DEPTH)
//   BYPASS    1   1: a same-cycle write to the selected register is forwarded to the read data
//   READ_REG  0   0: combinational reads; 1: read data registered (1-cycle latency)
//   ZERO_REG  0   1: register 0 is hardwired to zero, ignores writes, never busy
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   wr_en      in   1      write strobe (writeback)
//   wr_sel     in   AW     write address
//   wr_data    in   WIDTH  write data
//   rd_a_sel   in   AW     read port A address
//   rd_a_data  out  WIDTH  read port A data
//   rd_b_sel   in   AW     read port B address
//   rd_b_data  out  WIDTH  read port B data
//   issue_en   in   1      instruction issued; its destination becomes busy
//   issue_sel  in   AW     destination register of the issued instruction
//   busy_a     out  1      register at rd_a_sel has a pending write
//   busy_b     out  1      register at rd_b_sel has a pending write
//   hazard     out  1      busy_a | busy_b (decode stall request)
//   reg0_q     out  WIDTH  direct view of register 0
//   reg1_q     out  WIDTH  direct view of register 1
// BEHAVIOUR
//   Reset: rst_n low asynchronously clears every register, every busy bit, and
//     (READ_REG=1) the read data registers. All outputs read 0 while in reset.
//     Reset asserted mid-operation discards in-flight writes; no partial state.
//   Write: at posedge clk, if wr_en, regs[wr_sel] <= wr_data. With ZERO_REG=1 and
//     wr_sel==0, the write is dropped.
//   Read, READ_REG=0: rd_x_data = regs[rd_x_sel] combinationally. If BYPASS=1 and
//     wr_en && wr_sel==rd_x_sel, rd_x_data = wr_data in the same cycle.
//   Read, READ_REG=1: rd_x_data is registered at posedge from the same mux,
//     bypass included, giving 1-cycle latency. No tri-state: outputs are always driven.
//   ZERO_REG=1: register 0 reads 0 on both ports and through reg0_q, regardless
//     of bypass.
//   Scoreboard: busy[DEPTH-1:0], updated at posedge.
//     - issue_en sets busy[issue_sel].
//     - wr_en clears busy[wr_sel].
//     - If both target the same register in the same cycle, the set wins: the new
//       producer is pending.
//     - With ZERO_REG=1, busy[0] is never set.
//   busy_x = busy[rd_x_sel] & ~(BYPASS & wr_en & wr_sel==rd_x_sel). A completing
//     write, once forwarded, is not a hazard. busy_a, busy_b and hazard are
//     combinational in both READ_REG modes.
//   Read ports may select the same register; both return identical data.
//   reg0_q and reg1_q always show the committed register contents (no bypass).
// TESTING
//   1 Reset: drive rst_n=0 mid-cycle after arbitrary writes -> all rd data, reg0_q,
//     reg1_q and busy outputs = 0 immediately, without waiting for a clock edge.
//   2 Write/read: write 0x1234 to r5, then read A=r5, B=r5 -> both 0x1234
//     (READ_REG=1: the data appears one cycle after the address).
//   3 Bypass: same cycle wr_en, wr_sel=3, wr_data=0xBEEF, rd_a_sel=3 -> rd_a_data=0xBEEF,
//     busy_a=0. Repeat with BYPASS=0 -> old r3 value is returned.
//   4 Scoreboard: issue r2 -> busy_a=1 and hazard=1 with rd_a_sel=2. Issue r2 and
//     write r2 in the same cycle -> busy stays 1. A later write r2 -> busy clears.
//   5 ZERO_REG=1: write 0xFFFF to r0, then issue r0 -> r0 reads 0, busy_a=0, reg0_q=0.
//   6 Sweep: write to every address with distinct values at DEPTH=16, WIDTH=32 ->
//     all addresses read back their values; wr_sel=DEPTH-1 wraps no aliasing.

Source files
------------

// File: rtl/cpu_regfile_mp_if.sv
// Register file port bundle: writeback, two read ports, issue scoreboard and debug taps.
// master drives addresses/strobes (decode + writeback), slave is the register file.
interface cpu_regfile_mp_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_a_sel;
    logic [WIDTH-1:0] rd_a_data;
    logic [AW-1:0]    rd_b_sel;
    logic [WIDTH-1:0] rd_b_data;
    logic             issue_en;
    logic [AW-1:0]    issue_sel;
    logic             busy_a;
    logic             busy_b;
    logic             hazard;
    logic [WIDTH-1:0] reg0_q;
    logic [WIDTH-1:0] reg1_q;

    modport master (
        output wr_en, wr_sel, wr_data, rd_a_sel, rd_b_sel, issue_en, issue_sel,
        input  rd_a_data, rd_b_data, busy_a, busy_b, hazard, reg0_q, reg1_q
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_a_sel, rd_b_sel, issue_en, issue_sel,
        output rd_a_data, rd_b_data, busy_a, busy_b, hazard, reg0_q, reg1_q
    );
endinterface

// File: rtl/cpu_regfile_mp.sv
// Multi-port register file: 1 write, 2 read ports, optional bypass, busy scoreboard.
// Latency: reads combinational (READ_REG=0) or 1 cycle (READ_REG=1); busy/hazard always combinational.
// Backpressure: none accepted; hazard is the stall request decode must honour.
module cpu_regfile_mp #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    parameter int ZERO_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_regfile_mp_if.slave       rf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    logic [AW-1:0]    sel  [2];
    logic             hit  [2];
    logic [WIDTH-1:0] mux  [2];
    logic [WIDTH-1:0] rd_q [2];
    logic             busy_p [2];

    logic wr_drop;
    logic issue_drop;

    assign wr_drop    = (ZERO_REG != 0) && (rf.wr_sel == '0);
    assign issue_drop = (ZERO_REG != 0) && (rf.issue_sel == '0);

    assign sel[0] = rf.rd_a_sel;
    assign sel[1] = rf.rd_b_sel;

    // Issue is applied after the write clear so a new producer stays pending.
    always_comb begin
        busy_nxt = busy;
        if (rf.wr_en) begin
            busy_nxt[rf.wr_sel] = 1'b0;
        end
        if (rf.issue_en && !issue_drop) begin
            busy_nxt[rf.issue_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (rf.wr_en && !wr_drop) begin
                regs[rf.wr_sel] <= rf.wr_data;
            end
            busy <= busy_nxt;
        end
    end

    // Reset gating keeps a bypassed wr_data from leaking out while rst_n is low.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit[p]    = rf.wr_en && (rf.wr_sel == sel[p]);
            mux[p]    = regs[sel[p]];
            busy_p[p] = busy[sel[p]] & ~((BYPASS != 0) & hit[p]);
            if (!rst_n || ((ZERO_REG != 0) && (sel[p] == '0))) begin
                mux[p] = '0;
            end else if ((BYPASS != 0) && hit[p]) begin
                mux[p] = rf.wr_data;
            end
        end
    end

    if (READ_REG != 0) begin : g_rd_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q[0] <= '0;
                rd_q[1] <= '0;
            end else begin
                rd_q[0] <= mux[0];
                rd_q[1] <= mux[1];
            end
        end
    end else begin : g_rd_comb
        always_comb begin
            rd_q[0] = mux[0];
            rd_q[1] = mux[1];
        end
    end

    assign rf.rd_a_data = rd_q[0];
    assign rf.rd_b_data = rd_q[1];
    assign rf.busy_a    = busy_p[0];
    assign rf.busy_b    = busy_p[1];
    assign rf.hazard    = busy_p[0] | busy_p[1];
    assign rf.reg0_q    = (ZERO_REG != 0) ? '0 : regs[0];
    assign rf.reg1_q    = regs[1];
endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Bench for cpu_regfile_mp: two instances (bypass/comb/no-zero 16x8 and
// no-bypass/registered/zero-reg 32x16) driven by one directed stimulus stream.
module tb_cpu_regfile_mp;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        wen;
    logic [3:0]  wsel;
    logic [31:0] wdat;
    logic [3:0]  asel;
    logic [3:0]  bsel;
    logic        ien;
    logic [3:0]  isl;

    cpu_regfile_mp_if #(.WIDTH(16), .DEPTH(8))  if0 ();
    cpu_regfile_mp_if #(.WIDTH(32), .DEPTH(16)) if1 ();

    assign if0.wr_en     = wen;
    assign if0.wr_sel    = wsel[2:0];
    assign if0.wr_data   = wdat[15:0];
    assign if0.rd_a_sel  = asel[2:0];
    assign if0.rd_b_sel  = bsel[2:0];
    assign if0.issue_en  = ien;
    assign if0.issue_sel = isl[2:0];

    assign if1.wr_en     = wen;
    assign if1.wr_sel    = wsel;
    assign if1.wr_data   = wdat;
    assign if1.rd_a_sel  = asel;
    assign if1.rd_b_sel  = bsel;
    assign if1.issue_en  = ien;
    assign if1.issue_sel = isl;

    cpu_regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .READ_REG(0), .ZERO_REG(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (if0)
    );

    cpu_regfile_mp #(.WIDTH(32), .DEPTH(16), .BYPASS(0), .READ_REG(1), .ZERO_REG(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (if1)
    );

    int n_tot  = 0;
    int n_pass = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Reference model: plain register arrays and busy vectors per configuration.
    logic [15:0] m0 [8];
    logic [7:0]  b0;
    logic [31:0] m1 [16];
    logic [15:0] b1;
    logic [31:0] q1a, q1b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)  m0[i] <= '0;
            for (int i = 0; i < 16; i++) m1[i] <= '0;
            b0  <= '0;
            b1  <= '0;
            q1a <= '0;
            q1b <= '0;
        end else begin
            q1a <= (asel == 4'd0) ? 32'd0 : m1[asel];
            q1b <= (bsel == 4'd0) ? 32'd0 : m1[bsel];
            if (wen) m0[wsel[2:0]] <= wdat[15:0];
            if (wen && wsel != 4'd0) m1[wsel] <= wdat;
            for (int i = 0; i < 8; i++)
                b0[i] <= (ien && isl[2:0] == i[2:0]) ? 1'b1 :
                         (wen && wsel[2:0] == i[2:0]) ? 1'b0 : b0[i];
            for (int i = 0; i < 16; i++)
                b1[i] <= (ien && isl == i[3:0] && i != 0) ? 1'b1 :
                         (wen && wsel == i[3:0]) ? 1'b0 : b1[i];
        end
    end

    always @(negedge clk) begin : compare
        logic        ha, hb, ba0, bb0, ba1, bb1;
        logic [15:0] ea0, eb0;
        if (chk_on) begin
            ha  = wen && (wsel[2:0] == asel[2:0]);
            hb  = wen && (wsel[2:0] == bsel[2:0]);
            ea0 = !rst_n ? 16'd0 : ha ? wdat[15:0] : m0[asel[2:0]];
            eb0 = !rst_n ? 16'd0 : hb ? wdat[15:0] : m0[bsel[2:0]];
            ba0 = rst_n && b0[asel[2:0]] && !ha;
            bb0 = rst_n && b0[bsel[2:0]] && !hb;
            ba1 = rst_n && b1[asel];
            bb1 = rst_n && b1[bsel];
            chk("c0_rd_a",   32'(if0.rd_a_data), 32'(ea0));
            chk("c0_rd_b",   32'(if0.rd_b_data), 32'(eb0));
            chk("c0_busy_a", 32'(if0.busy_a),    32'(ba0));
            chk("c0_busy_b", 32'(if0.busy_b),    32'(bb0));
            chk("c0_hazard", 32'(if0.hazard),    32'(ba0 | bb0));
            chk("c0_reg0",   32'(if0.reg0_q),    32'(rst_n ? m0[0] : 16'd0));
            chk("c0_reg1",   32'(if0.reg1_q),    32'(rst_n ? m0[1] : 16'd0));
            chk("c1_rd_a",   if1.rd_a_data,      rst_n ? q1a : 32'd0);
            chk("c1_rd_b",   if1.rd_b_data,      rst_n ? q1b : 32'd0);
            chk("c1_busy_a", 32'(if1.busy_a),    32'(ba1));
            chk("c1_busy_b", 32'(if1.busy_b),    32'(bb1));
            chk("c1_hazard", 32'(if1.hazard),    32'(ba1 | bb1));
            chk("c1_reg0",   if1.reg0_q,         32'd0);
            chk("c1_reg1",   if1.reg1_q,         rst_n ? m1[1] : 32'd0);
        end
    end

    task automatic drv(input logic w, input logic [3:0] ws, input logic [31:0] wd,
                       input logic [3:0] as, input logic [3:0] bs,
                       input logic ie, input logic [3:0] is_sel);
        wen  = w;
        wsel = ws;
        wdat = wd;
        asel = as;
        bsel = bs;
        ien  = ie;
        isl  = is_sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_on = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_c0_rd_a", 32'(if0.rd_a_data), 32'd0);
        chk("reset_c1_hazard", 32'(if1.hazard), 32'd0);

        // Write then read r5 on both ports
        drv(1, 5, 32'h0000_1234, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 5, 5, 0, 0);
        #1;
        chk("wr_rd_c0_a", 32'(if0.rd_a_data), 32'h1234);
        chk("wr_rd_c0_b", 32'(if0.rd_b_data), 32'h1234);
        tick();
        chk("wr_rd_c1_a", if1.rd_a_data, 32'h1234);
        chk("wr_rd_c1_b", if1.rd_b_data, 32'h1234);

        // Issue and write r3 together (set wins), then a bypassed write to r3
        drv(1, 3, 32'h0000_0333, 0, 0, 1, 3);
        tick();
        drv(1, 3, 32'h0000_BEEF, 3, 5, 0, 0);
        #1;
        chk("byp_c0_data", 32'(if0.rd_a_data), 32'hBEEF);
        chk("byp_c0_busy", 32'(if0.busy_a), 32'd0);
        chk("byp_c1_busy", 32'(if1.busy_a), 32'd1);
        tick();
        chk("nobyp_c1_old", if1.rd_a_data, 32'h0333);
        drv(0, 0, 0, 3, 5, 0, 0);
        tick();
        chk("nobyp_c1_new", if1.rd_a_data, 32'hBEEF);

        // Scoreboard on r2
        drv(0, 0, 0, 2, 0, 1, 2);
        tick();
        drv(0, 0, 0, 2, 0, 0, 0);
        #1;
        chk("sb_busy_a", 32'(if0.busy_a), 32'd1);
        chk("sb_hazard", 32'(if0.hazard), 32'd1);
        chk("sb_c1_busy", 32'(if1.busy_a), 32'd1);
        tick();
        drv(1, 2, 32'h0000_0022, 2, 0, 1, 2);
        tick();
        drv(0, 0, 0, 2, 0, 0, 0);
        #1;
        chk("sb_set_wins", 32'(if0.busy_a), 32'd1);
        tick();
        drv(1, 2, 32'h0000_2222, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 2, 2, 0, 0);
        #1;
        chk("sb_clear_c0", 32'(if0.busy_a), 32'd0);
        chk("sb_clear_c1", 32'(if1.hazard), 32'd0);
        tick();

        // Register 0 handling (hardwired only on the zero-reg instance)
        drv(1, 0, 32'h0000_FFFF, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 1, 0);
        tick();
        drv(0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("z_c1_busy_a", 32'(if1.busy_a), 32'd0);
        chk("z_c0_reg0", 32'(if0.reg0_q), 32'hFFFF);
        chk("z_c0_busy_a", 32'(if0.busy_a), 32'd1);
        tick();
        chk("z_c1_rd_a", if1.rd_a_data, 32'd0);
        chk("z_c1_reg0", if1.reg0_q, 32'd0);

        // Sweep every 4-bit address; the 8-deep instance aliases on wr_sel[2:0]
        for (int i = 0; i < 16; i++) begin
            drv(1, 4'(i), {16'hC0DE, 16'(i * 16'h1111)}, 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            drv(0, 0, 0, 4'(i), 4'(15 - i), 0, 0);
            tick();
        end
        drv(0, 0, 0, 15, 7, 0, 0);
        #1;
        chk("sweep_c0_r7", 32'(if0.rd_b_data), 32'hFFFF);
        tick();
        chk("sweep_c1_r15", if1.rd_a_data, 32'hC0DE_FFFF);
        chk("sweep_c1_r7", if1.rd_b_data, 32'hC0DE_7777);

        // Asynchronous reset mid-cycle with a bypass hit and a busy register selected
        drv(0, 0, 0, 0, 0, 1, 1);
        tick();
        drv(1, 5, 32'h0000_5555, 5, 1, 1, 4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_c0_rd_a",   32'(if0.rd_a_data), 32'd0);
        chk("rst_c0_rd_b",   32'(if0.rd_b_data), 32'd0);
        chk("rst_c0_reg0",   32'(if0.reg0_q),    32'd0);
        chk("rst_c0_reg1",   32'(if0.reg1_q),    32'd0);
        chk("rst_c0_hazard", 32'(if0.hazard),    32'd0);
        chk("rst_c1_rd_a",   if1.rd_a_data,      32'd0);
        chk("rst_c1_reg1",   if1.reg1_q,         32'd0);
        chk("rst_c1_busy_b", 32'(if1.busy_b),    32'd0);
        tick();
        drv(0, 0, 0, 5, 1, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_c1_r5", if1.rd_a_data, 32'd0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
